// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    // Operation codes carried on opCode
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    // Bit positions inside the 4-bit flags word {V,C,N,Z}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    // Control FSM of the top level
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock edge.
// Bit 0 is consumed on the start edge, so the product is ready DATA_WIDTH-1 edges later
// and done pulses for exactly one cycle with the full product on 'product'.
module alu_seq_mul #(
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned RES_W     = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  done,
    output logic [RES_W-1:0]      product
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [RES_W-1:0]      mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [RES_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;

    // Next-state: load on start (consuming bit 0), then accumulate one bit per edge
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = RES_W'(operand_a) << 1;
            mplier_d = operand_b >> 1;
            acc_d    = operand_b[0] ? RES_W'(operand_a) : '0;
            cnt_d    = CNT_W'(1);
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Last bit processed on this edge
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end
        end
    end

    // State registers; reset abandons any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_hs_pipe.sv
// Handshaked ALU with a registered output stage and an iterative multiplier.
// Build option: define ALU_FLAGS_EN to generate the {V,C,N,Z} flags; otherwise the
// flags port is tied to zero and no flag logic exists.
module alu_hs_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned RES_W     = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operandA,
    input  logic [DATA_WIDTH-1:0] operandB,
    input  logic [2:0]            opCode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_W-1:0]      opResult,
    output logic [3:0]            flags,
    output logic                  busy
);

    localparam int unsigned SH_W = $clog2(DATA_WIDTH);

    alu_state_e state_q, state_d;

    logic                  out_valid_q, out_valid_d;
    logic [RES_W-1:0]      res_q, res_d;

    logic                  accept;
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_done;
    logic [RES_W-1:0]      mul_product;

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [SH_W-1:0]       sh_amt;
    logic [RES_W-1:0]      alu_res;

    // Only accept when idle and the output register is free or draining this edge
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opCode == OP_MUL);
    assign mul_start = accept && is_mul;

    assign sum    = {1'b0, operandA} + {1'b0, operandB};
    assign diff   = {1'b0, operandA} - {1'b0, operandB};
    assign sh_amt = operandB[SH_W-1:0];

    alu_seq_mul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .operand_a (operandA),
        .operand_b (operandB),
        .done      (mul_done),
        .product   (mul_product)
    );

    // Single-cycle datapath result
    always_comb begin
        alu_res = '0;
        case (opCode)
            OP_ADD:  alu_res = RES_W'(sum);
            OP_SUB:  alu_res = {{(RES_W - DATA_WIDTH - 1){diff[DATA_WIDTH]}}, diff};
            OP_XOR:  alu_res = RES_W'(operandA ^ operandB);
            OP_AND:  alu_res = RES_W'(operandA & operandB);
            OP_OR:   alu_res = RES_W'(operandA | operandB);
            OP_SHL:  alu_res = RES_W'(operandA) << sh_amt;
            OP_SHR:  alu_res = RES_W'(operandA >> sh_amt);
            default: alu_res = '0;
        endcase
    end

    // Control FSM next-state: IDLE while single-cycle ops flow, MUL_BUSY until done
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (mul_start) state_d = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_done)  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output register next-state: drain on handshake, reload on completion
    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && !is_mul) begin
            out_valid_d = 1'b1;
            res_d       = alu_res;
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            res_d       = mul_product;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q, flags_d;

    // Flags next-state, loaded together with the result
    always_comb begin
        flags_d = flags_q;
        if (accept && !is_mul) begin
            flags_d         = '0;
            flags_d[FLAG_Z] = (alu_res == '0);
            flags_d[FLAG_N] = alu_res[RES_W-1];
            if (opCode == OP_ADD) begin
                flags_d[FLAG_C] = sum[DATA_WIDTH];
                flags_d[FLAG_V] = (operandA[DATA_WIDTH-1] == operandB[DATA_WIDTH-1]) &&
                                  (sum[DATA_WIDTH-1] != operandA[DATA_WIDTH-1]);
            end else if (opCode == OP_SUB) begin
                flags_d[FLAG_C] = diff[DATA_WIDTH];
                flags_d[FLAG_V] = (operandA[DATA_WIDTH-1] != operandB[DATA_WIDTH-1]) &&
                                  (diff[DATA_WIDTH-1] != operandA[DATA_WIDTH-1]);
            end
        end else if (mul_done) begin
            flags_d         = '0;
            flags_d[FLAG_Z] = (mul_product == '0);
            flags_d[FLAG_N] = mul_product[RES_W-1];
        end
    end

    // Flags register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0;
`endif

    assign out_valid = out_valid_q;
    assign opResult  = res_q;
    assign busy      = (state_q == ST_MUL_BUSY);

endmodule

// File: tb/tb_alu_hs_pipe.sv
// Self-checking bench for alu_hs_pipe: directed corner cases then random traffic,
// all checked against a transaction-level reference model.
module tb_alu_hs_pipe;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] operandA;
    logic [DW-1:0] operandB;
    logic [2:0]    opCode;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] opResult;
    logic [3:0]    flags;
    logic          busy;

    always #5 clk = ~clk;

    alu_hs_pipe #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operandA  (operandA),
        .operandB  (operandB),
        .opCode    (opCode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opResult  (opResult),
        .flags     (flags),
        .busy      (busy)
    );

    int unsigned n_vec    = 0;
    int unsigned n_miscmp = 0;

    // Reference model state: pending output and remaining multiply cycles
    bit            m_valid;
    logic [RW-1:0] m_res;
    logic [3:0]    m_flags;
    int            m_mul_left;
    logic [RW-1:0] m_mul_res;
    logic [3:0]    m_mul_flags;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural result of one operation, returned as {flags, result}
    function automatic logic [RW+3:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        longint        ua  = longint'(a);
        longint        ub  = longint'(b);
        longint        lim = longint'(1) << (DW - 1);
        longint        sa  = a[DW-1] ? ua - (longint'(1) << DW) : ua;
        longint        sb  = b[DW-1] ? ub - (longint'(1) << DW) : ub;
        longint        r   = 0;
        longint        s   = 0;
        bit            c   = 1'b0;
        bit            v   = 1'b0;
        logic [RW-1:0] res;
        logic [3:0]    f;
        case (op)
            3'd0: begin
                r = ua + ub;
                c = (r >= (longint'(1) << DW));
                s = sa + sb;
                v = (s >= lim) || (s < -lim);
            end
            3'd1: begin
                r = ua - ub;
                c = (ua < ub);
                s = sa - sb;
                v = (s >= lim) || (s < -lim);
            end
            3'd2:    r = ua ^ ub;
            3'd3:    r = ua & ub;
            3'd4:    r = ua | ub;
            3'd5:    r = ua * ub;
            3'd6:    r = ua << (ub % DW);
            default: r = ua >> (ub % DW);
        endcase
        res = r[RW-1:0];
        f   = {v, c, res[RW-1], res == '0};
`ifndef ALU_FLAGS_EN
        f = 4'b0;
`endif
        return {f, res};
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check in_ready, advance model
    task automatic step(input logic v, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic rdy);
        logic          exp_ready;
        logic [RW+3:0] t;
        @(negedge clk);
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("opResult", 64'(opResult), 64'(m_res));
            check_eq("flags", 64'(flags), 64'(m_flags));
        end
        check_eq("busy", 64'(busy), 64'(m_mul_left != 0));
        in_valid  = v;
        opCode    = op;
        operandA  = a;
        operandB  = b;
        out_ready = rdy;
        #1;
        exp_ready = (m_mul_left == 0) && (!m_valid || rdy);
        check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
        if (m_valid && rdy) m_valid = 1'b0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_valid = 1'b1;
                m_res   = m_mul_res;
                m_flags = m_mul_flags;
            end
        end
        if (v && exp_ready) begin
            t = ref_alu(op, a, b);
            if (op == 3'd5) begin
                m_mul_left  = DW;
                m_mul_res   = t[RW-1:0];
                m_mul_flags = t[RW+3:RW];
            end else begin
                m_valid = 1'b1;
                m_res   = t[RW-1:0];
                m_flags = t[RW+3:RW];
            end
        end
    endtask

    function automatic logic [DW-1:0] pick_operand();
        logic [DW-1:0] corner [4];
        corner[0] = '0;
        corner[1] = '1;
        corner[2] = DW'(1) << (DW - 1);
        corner[3] = DW'(1);
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
        return DW'($urandom);
    endfunction

    task automatic model_reset();
        m_valid     = 1'b0;
        m_res       = '0;
        m_flags     = '0;
        m_mul_left  = 0;
        m_mul_res   = '0;
        m_mul_flags = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        opCode    = '0;
        operandA  = '0;
        operandB  = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst out_valid", 64'(out_valid), 64'd0);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst opResult", 64'(opResult), 64'd0);
        check_eq("rst flags", 64'(flags), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("rst in_ready", 64'(in_ready), 64'd1);

        // ADD carry out, SUB borrow/negative, SUB signed overflow
        step(1'b1, 3'd0, 16'hFFFF, 16'h0001, 1'b1);
        step(1'b1, 3'd1, 16'h0003, 16'h0005, 1'b1);
        step(1'b1, 3'd1, 16'h8000, 16'h0001, 1'b1);
        step(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);

        // Full-scale multiply, then idle through the busy window
        step(1'b1, 3'd5, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < DW + 2; i++) step(1'b1, 3'd0, 16'h1111, 16'h2222, 1'b1);

        // Back-pressure: XOR held, AND stalls, then both drain in order
        step(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0);
        step(1'b1, 3'd3, 16'h00FF, 16'h0F0F, 1'b0);
        step(1'b1, 3'd3, 16'h00FF, 16'h0F0F, 1'b0);
        step(1'b1, 3'd3, 16'h00FF, 16'h0F0F, 1'b1);
        step(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);

        // Shifts: upper bits of B ignored
        step(1'b1, 3'd6, 16'h8001, 16'h0013, 1'b1);
        step(1'b1, 3'd7, 16'h8001, 16'h000F, 1'b1);
        step(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);

        // Reset in the middle of a multiply
        step(1'b1, 3'd5, 16'h1234, 16'h5678, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midmul out_valid", 64'(out_valid), 64'd0);
        check_eq("midmul busy", 64'(busy), 64'd0);
        check_eq("midmul opResult", 64'(opResult), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midmul in_ready", 64'(in_ready), 64'd1);
        step(1'b1, 3'd0, 16'h0002, 16'h0002, 1'b1);
        step(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);

        // Random traffic with random back-pressure
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), pick_operand(),
                 pick_operand(), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < DW + 3; i++) step(1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
